// File: rtl/mean_pkg.sv
// mean_pkg: shared defaults and round/saturate helper for the sliding-mean output path
package mean_pkg;
   localparam int DATA_WITH_DEF  = 24;
   localparam int MEAN_LEVEL_DEF = 7;
   localparam int FIFO_DEPTH_DEF = 4;
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
   localparam int LEVEL_W_DEF = level_w(FIFO_DEPTH_DEF);
   // Round-half-up then saturate to dw bits; a 64-bit datapath covers any dw+ml+1 up to 64
   function automatic logic [63:0] round_sat(input logic [63:0] d, input int dw, input int ml);
      logic [63:0] q;
      q = (d + (64'd1 << (ml - 1))) >> ml;
      return (q >= (64'd1 << dw)) ? (64'd1 << dw) - 64'd1 : q;
   endfunction
endpackage

// File: rtl/mean_sync_fifo.sv
// mean_sync_fifo: synchronous FIFO with registered head output
//   clk, rst_n    : clock, async active-low reset
//   push, din     : write request and data (accepted when not full, or full with a pop)
//   pop           : read request (ignored when empty)
//   full, empty   : occupancy flags
//   level         : occupancy 0..DEPTH
//   dout          : registered head entry
module mean_sync_fifo
   import mean_pkg::*;
#(
   parameter int WIDTH = DATA_WITH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int LW = level_w(DEPTH),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   assign empty   = level == '0;
   assign full    = level == LW'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   // dout loads din when the new word becomes head (empty, or the only entry is popping)
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
         if (do_push && (empty || (do_pop && level == LW'(1)))) dout <= din;
         else if (do_pop && level > LW'(1)) dout <= mem[rd_ptr + 1'b1];
      end
endmodule

// File: rtl/mean_sink.sv
// mean_sink: captures filter result strobes, rounds/saturates, buffers for downstream handshake
//   clk, rst_n     : clock, async active-low reset
//   iReady, iData  : filter strobe and wide filtered word
//   oValid, oData  : head result available / value
//   iAck           : downstream accepts head when oValid
//   oOverflow      : sticky drop flag, cleared by iClrOvf
//   oLevel         : FIFO occupancy
module mean_sink
   import mean_pkg::*;
#(
   parameter int DATA_WITH  = DATA_WITH_DEF,
   parameter int MEAN_Level = MEAN_LEVEL_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            iReady,
   input  logic [DATA_WITH+MEAN_Level-1:0] iData,
   output logic                            oValid,
   output logic [DATA_WITH-1:0]            oData,
   input  logic                            iAck,
   output logic                            oOverflow,
   input  logic                            iClrOvf,
   output logic [$clog2(FIFO_DEPTH):0]     oLevel
);
   logic                 ready_d, capture, pop, full, empty, ovf_evt;
   logic [DATA_WITH-1:0] rounded;
   assign capture = iReady & ~ready_d;
   assign pop     = iAck & ~empty;
   assign ovf_evt = capture & full & ~pop;
   assign rounded = DATA_WITH'(round_sat(64'(iData), DATA_WITH, MEAN_Level));
   assign oValid  = ~empty;
   // ready_d resets high so a strobe already asserted at reset release is ignored
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ready_d   <= 1'b1;
         oOverflow <= 1'b0;
      end else begin
         ready_d   <= iReady;
         oOverflow <= ovf_evt | (oOverflow & ~iClrOvf);
      end
   mean_sync_fifo #(.WIDTH(DATA_WITH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .din   (rounded),
      .pop   (iAck),
      .full  (full),
      .empty (empty),
      .level (oLevel),
      .dout  (oData)
   );
endmodule

// File: tb/tb_mean_sink.sv
// tb_mean_sink: table vectors plus scoreboard model for mean_sink (D=24, M=7, depth 4)
module tb_mean_sink;
   logic        clk = 0, rst_n = 0;
   logic        iReady = 0, iAck = 0, iClrOvf = 0;
   logic [30:0] iData = '0;
   logic        oValid, oOverflow;
   logic [23:0] oData;
   logic [2:0]  oLevel;
   int n_chk = 0, n_fail = 0;

   mean_sink dut (
      .clk(clk), .rst_n(rst_n), .iReady(iReady), .iData(iData), .oValid(oValid),
      .oData(oData), .iAck(iAck), .oOverflow(oOverflow), .iClrOvf(iClrOvf), .oLevel(oLevel)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] ref_round(input logic [30:0] d);
      logic [31:0] s;
      s = {1'b0, d} + 32'd64;
      return s[31] ? 24'hFFFFFF : s[30:7];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard model: queue holds expected results in drain order
   logic [23:0] m_q[$];
   bit          m_rd = 1, m_ovf = 0, m_cap, m_pop;
   int          m_sz;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_q.delete();
         m_rd = 1;
         m_ovf = 0;
      end else begin
         m_sz  = m_q.size();
         m_cap = iReady && !m_rd;
         m_pop = m_sz > 0 && iAck;
         if (m_pop) void'(m_q.pop_front());
         if (m_cap && (m_sz < 4 || m_pop)) m_q.push_back(ref_round(iData));
         if (m_cap && m_sz == 4 && !m_pop) m_ovf = 1;
         else if (iClrOvf) m_ovf = 0;
         m_rd = iReady;
      end

   always @(negedge clk)
      if (rst_n) begin
         check("sb_valid", 32'(oValid), 32'(m_q.size() != 0));
         check("sb_level", 32'(oLevel), 32'(m_q.size()));
         check("sb_ovf", 32'(oOverflow), 32'(m_ovf));
         if (m_q.size() != 0) check("sb_data", 32'(oData), 32'(m_q[0]));
      end

   typedef struct {logic [30:0] d; logic [23:0] e;} vec_t;
   vec_t vec[7];
   int   exp4[4];

   task automatic strobe(input int v);
      iReady = 1;
      iData  = 31'(v);
      @(negedge clk);
      iReady = 0;
      @(negedge clk);
   endtask

   initial begin
      vec[0] = '{31'h0000_00C0, 24'h000002};
      vec[1] = '{31'h0000_00BF, 24'h000001};
      vec[2] = '{31'h0000_0040, 24'h000001};
      vec[3] = '{31'h0000_003F, 24'h000000};
      vec[4] = '{31'h7FFF_FFFF, 24'hFFFFFF};
      vec[5] = '{31'h7FFF_FFBF, 24'hFFFFFF};
      vec[6] = '{31'h7FFF_FF3F, 24'hFFFFFE};
      exp4 = '{11, 12, 13, 99};
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(oValid), 0);
      check("rst_data", 32'(oData), 0);
      check("rst_ovf", 32'(oOverflow), 0);
      check("rst_level", 32'(oLevel), 0);
      rst_n = 1;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         iReady = 1;
         iData  = vec[i].d;
         @(negedge clk);
         iReady = 0;
         check("round_valid", 32'(oValid), 1);
         check("round_data", 32'(oData), 32'(vec[i].e));
         iAck = 1;
         @(negedge clk);
         iAck = 0;
         check("round_drain", 32'(oLevel), 0);
      end
      iReady = 1;
      iData  = 31'h100;
      @(negedge clk);
      check("wide_valid", 32'(oValid), 1);
      repeat (4) @(negedge clk);
      iReady = 0;
      @(negedge clk);
      check("wide_level", 32'(oLevel), 1);
      check("wide_data", 32'(oData), 2);
      iAck = 1;
      @(negedge clk);
      iAck = 0;
      for (int i = 1; i <= 5; i++) strobe(i * 128);
      check("ovf_level", 32'(oLevel), 4);
      check("ovf_flag", 32'(oOverflow), 1);
      iClrOvf = 1;
      @(negedge clk);
      iClrOvf = 0;
      check("ovf_clr", 32'(oOverflow), 0);
      iReady  = 1;
      iData   = 31'(6 * 128);
      iClrOvf = 1;
      @(negedge clk);
      iReady  = 0;
      iClrOvf = 0;
      check("ovf_clr_vs_drop", 32'(oOverflow), 1);
      iClrOvf = 1;
      @(negedge clk);
      iClrOvf = 0;
      check("ovf_clr2", 32'(oOverflow), 0);
      iAck = 1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_order", 32'(oData), 32'(i));
         @(negedge clk);
      end
      iAck = 0;
      check("drain_empty", 32'(oLevel), 0);
      for (int i = 10; i <= 13; i++) strobe(i * 128);
      iReady = 1;
      iData  = 31'(99 * 128);
      iAck   = 1;
      @(negedge clk);
      iReady = 0;
      iAck   = 0;
      check("fpp_ovf", 32'(oOverflow), 0);
      check("fpp_level", 32'(oLevel), 4);
      check("fpp_head", 32'(oData), 11);
      iAck = 1;
      for (int i = 0; i < 4; i++) begin
         check("fpp_order", 32'(oData), 32'(exp4[i]));
         @(negedge clk);
      end
      iAck = 0;
      check("fpp_empty", 32'(oLevel), 0);
      for (int i = 20; i <= 23; i++) strobe(i * 128);
      iAck = 1;
      @(negedge clk);
      iAck = 0;
      check("mid_level", 32'(oLevel), 3);
      #2;
      rst_n  = 0;
      iReady = 1;
      #1;
      check("arst_valid", 32'(oValid), 0);
      check("arst_level", 32'(oLevel), 0);
      check("arst_data", 32'(oData), 0);
      check("arst_ovf", 32'(oOverflow), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      check("no_cap_after_rst", 32'(oLevel), 0);
      iReady = 0;
      @(negedge clk);
      iReady = 1;
      iData  = 31'h80;
      @(negedge clk);
      iReady = 0;
      check("cap_after_rst", 32'(oLevel), 1);
      check("cap_after_rst_data", 32'(oData), 1);
      iAck = 1;
      @(negedge clk);
      iAck = 0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mean_sink.md
# mean_sink

Output-side consumer for the sliding-mean filter. Detects each result strobe on the filter's ready line and samples the wide filtered word. Rounds and saturates the word back to the native sample width, then buffers it in a small FIFO. Downstream logic drains results through a valid/acknowledge handshake, and overflow is reported through a sticky flag.

## Interface
Parameters:
- DATA_WITH, 24, native sample width of output words
- MEAN_Level, 7, filter shift; input word is DATA_WITH+MEAN_Level bits, fractional part MEAN_Level bits (≥1)
- FIFO_DEPTH, 4, result buffer depth; power of two, ≥2

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- iReady  in  1  result strobe from filter (level pulse, ≥1 cycle high)
- iData  in  DATA_WITH+MEAN_Level  filtered word, unsigned, stable while iReady high
- oValid  out  1  FIFO non-empty; oData holds head entry
- oData  out  DATA_WITH  rounded/saturated head result
- iAck  in  1  downstream accepts head when oValid&iAck
- oOverflow  out  1  sticky: a capture was dropped because FIFO full
- iClrOvf  in  1  synchronous clear of oOverflow
- oLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Edge detect: register iReady_d <= iReady; capture = iReady & ~iReady_d. One capture per strobe regardless of strobe width.
- Rounding (unsigned, round-half-up): sum = iData + 2^(MEAN_Level-1), computed DATA_WITH+MEAN_Level+1 bits; q = sum >> MEAN_Level; if q ≥ 2^DATA_WITH, result = all ones, else q[DATA_WITH-1:0].
- Push on capture if FIFO not full, or if full and a pop occurs the same cycle (simultaneous push+pop when full is legal, no overflow).
- Pop on oValid & iAck. iAck with oValid low is ignored.
- Push and pop same cycle at any level: occupancy unchanged, both take effect.
- Capture while full with no pop: sample discarded, oOverflow <= 1, FIFO contents unchanged.
- iClrOvf clears oOverflow; overflow event in the same cycle wins (flag stays 1).
- Pointers wrap modulo FIFO_DEPTH; oLevel counts 0..FIFO_DEPTH.

## Timing
- Reset values: oValid 0, oData 0, oOverflow 0, oLevel 0, pointers 0, iReady_d 1. With iReady_d at 1, a strobe already high at reset release is not captured.
- Latency: capture at rising edge k; oValid=1 and oData valid from edge k (visible the cycle after the strobe's first high sample) when FIFO was empty.
- oData is registered and updates on the edge following a pop, or on the push into an empty FIFO. It is never combinational from iData.
- After a pop, the next entry is presented on the following cycle with oValid continuous. Back-to-back iAck drains one word per cycle.
- Reset assertion mid-operation clears all state immediately. Buffered results are lost; no output during reset.

## Structure
- Shared package/include (mean_pkg): DATA_WITH/MEAN_Level defaults, round_sat function (round-half-up + saturate), and the occupancy width constant. The filter testbench reuses the same function as its model.
- One natural sub-module: mean_sync_fifo (parameterised width/depth, push/pop/full/empty/level). The top holds edge detect, rounding, overflow flag.

## Test plan
- Rounding: D=24, M=7; strobe with iData=0xC0 → oData=0x000002. iData=0xBF → 0x000001. iData=0x40 → 0x000001. iData=0x3F → 0x000000.
- Saturation: iData=0x7FFF_FFFF → oData=0xFF_FFFF. iData=0x7FFF_FFBF → 0xFF_FFFF; 0x7FFF_FF3F → 0xFF_FFFE.
- Strobe width: iReady held high 5 cycles → exactly one entry, oLevel=1, oValid rises one edge after first high sample.
- Overflow: iAck=0, 5 strobes with values 1..5 (×128) → oLevel=4, oOverflow=1. Drain yields 1,2,3,4. iClrOvf clears flag; iClrOvf coincident with a dropped capture leaves flag 1.
- Full push+pop: FIFO full, strobe coincident with iAck → no overflow, oLevel stays 4, new value appears last in drain order.
- Reset: rst_n low mid-drain with 3 entries → oValid/oLevel/oData 0 asynchronously. iReady high during release → no capture until next rising strobe.
